// File: rtl/coin_pkg.sv
// Shared coin codes and coin-acceptor state encoding.
// The coin codes also drive the vending FSM's bani input.
package coin_pkg;

    typedef enum logic [1:0] {
        M0  = 2'b00,
        M5  = 2'b01,
        B10 = 2'b10,
        B50 = 2'b11
    } coin_e;

    typedef enum logic [2:0] {
        StArm,
        StIdle,
        StMeasure,
        StHold,
        StDiscard,
        StJam
    } acc_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous input line.
// The asynchronous active-high reset clears both flops to 0.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] ff_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ff_q <= 2'b00;
        end else begin
            ff_q <= {ff_q[0], d_i};
        end
    end

    assign q_o = ff_q[1];

endmodule

// File: rtl/coin_acceptor.sv
// Coin sensor front end: measures synchronized pulse widths and emits one-cycle coin codes.
// Rejects out-of-window pulses, flags a jammed sensor and enforces a hold-off between codes.
module coin_acceptor
    import coin_pkg::*;
#(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned W5_MIN  = 3,
    parameter int unsigned W5_MAX  = 5,
    parameter int unsigned W10_MIN = 7,
    parameter int unsigned W10_MAX = 9,
    parameter int unsigned W50_MIN = 12,
    parameter int unsigned W50_MAX = 15,
    parameter int unsigned JAM_LIM = 40,
    parameter int unsigned GAP     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sensor,
    output logic [1:0] bani,
    output logic       reject,
    output logic       jam,
    output logic       busy
);

    if (!(W5_MIN >= 1 && W5_MIN <= W5_MAX && W5_MAX < W10_MIN && W10_MIN <= W10_MAX &&
          W10_MAX < W50_MIN && W50_MIN <= W50_MAX && W50_MAX < JAM_LIM &&
          JAM_LIM < (2 ** CNT_W) && GAP >= 1 && GAP < (2 ** CNT_W))) begin : g_param_check
        $error("coin_acceptor: windows, JAM_LIM, GAP or CNT_W are inconsistent");
    end

    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
    localparam logic [CNT_W-1:0] ArmFill = CNT_W'(2);
    localparam logic [CNT_W-1:0] GapLd   = CNT_W'(GAP);
    localparam logic [CNT_W-1:0] JamLim  = CNT_W'(JAM_LIM);
    localparam logic [CNT_W-1:0] W5Lo    = CNT_W'(W5_MIN);
    localparam logic [CNT_W-1:0] W5Hi    = CNT_W'(W5_MAX);
    localparam logic [CNT_W-1:0] W10Lo   = CNT_W'(W10_MIN);
    localparam logic [CNT_W-1:0] W10Hi   = CNT_W'(W10_MAX);
    localparam logic [CNT_W-1:0] W50Lo   = CNT_W'(W50_MIN);
    localparam logic [CNT_W-1:0] W50Hi   = CNT_W'(W50_MAX);

    function automatic coin_e classify(input logic [CNT_W-1:0] width);
        if (width >= W5Lo && width <= W5Hi) begin
            return M5;
        end else if (width >= W10Lo && width <= W10Hi) begin
            return B10;
        end else if (width >= W50Lo && width <= W50Hi) begin
            return B50;
        end
        return M0;
    endfunction

    logic             sensor_s;
    acc_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    coin_e            bani_q, bani_d;
    logic             reject_q, reject_d;
    logic             jam_q, jam_d;
    logic             busy_q, busy_d;
    coin_e            code;

    sync_2ff u_sensor_sync (
        .clk_i (clk),
        .rst_i (reset),
        .d_i   (sensor),
        .q_o   (sensor_s)
    );

    assign code = classify(cnt_q);

    // cnt_q is shared: fill delay in ARM, width in MEASURE, countdown in HOLD.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bani_d   = M0;
        reject_d = 1'b0;
        jam_d    = jam_q;
        unique case (state_q)
            StArm: begin
                if (cnt_q < ArmFill) begin
                    cnt_d = cnt_q + CntOne;
                end else if (!sensor_s) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end
            end
            StIdle: begin
                if (sensor_s) begin
                    cnt_d   = CntOne;
                    state_d = StMeasure;
                end
            end
            StMeasure: begin
                if (sensor_s) begin
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + CntOne;
                    end
                    if (cnt_d == JamLim) begin
                        jam_d   = 1'b1;
                        state_d = StJam;
                    end
                end else begin
                    bani_d   = code;
                    reject_d = (code == M0);
                    cnt_d    = GapLd;
                    state_d  = StHold;
                end
            end
            StHold: begin
                if (sensor_s) begin
                    state_d = StDiscard;
                end else if (cnt_q <= CntOne) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            StDiscard: begin
                if (!sensor_s) begin
                    reject_d = 1'b1;
                    cnt_d    = GapLd;
                    state_d  = StHold;
                end
            end
            StJam: begin
                if (!sensor_s) begin
                    jam_d    = 1'b0;
                    reject_d = 1'b1;
                    cnt_d    = GapLd;
                    state_d  = StHold;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = StArm;
            end
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StArm;
            cnt_q    <= '0;
            bani_q   <= M0;
            reject_q <= 1'b0;
            jam_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bani_q   <= bani_d;
            reject_q <= reject_d;
            jam_q    <= jam_d;
            busy_q   <= busy_d;
        end
    end

    assign bani   = bani_q;
    assign reject = reject_q;
    assign jam    = jam_q;
    assign busy   = busy_q;

endmodule
